// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-code bundle between the board keypad, the scanner and the
// charging-station state machine.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_strobe;

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_strobe
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_strobe
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with per-scan debounce; code commits DEBOUNCE_SCANS scans after a stable key.
// Define KEY_REPEAT_EN for a repeat strobe every REPEAT_SCANS scans while a key is held.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned REPEAT_SCANS   = 40
) (
  input logic             clk,
  input logic             rst,
  keypad_scanner_if.master kp
);

  localparam int unsigned      DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam int unsigned      MATCH_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(DEBOUNCE_SCANS);
  localparam logic [3:0]       KEY_NONE   = 4'hF;
  localparam logic [1:0]       COL_LAST   = 2'd3;

  function automatic logic [3:0] key_at(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd15:   code = 4'hD;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [3:0][3:0]  press_q, press_d;
  logic             scan_end_q, scan_end_d;
  logic [3:0]       cand_q, cand_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [3:0]       key_q, key_d;
  logic             strobe_q, strobe_d;
  logic             slot_last;
  logic             commit;
  logic [4:0]       hits;
  logic [3:0]       hit_code;
  logic [3:0]       raw;

  // Rows idle high, so the synchroniser resets to "no key".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= kp.row_in;
      row_sync_q <= row_meta_q;
    end
  end

  always_comb begin
    slot_last  = (div_q == DIV_LAST);
    div_d      = slot_last ? '0 : div_q + DIV_W'(1);
    col_d      = slot_last ? col_q + 2'd1 : col_q;
    press_d    = press_q;
    if (slot_last) begin
      press_d[col_q] = ~row_sync_q;
    end
    scan_end_d = slot_last && (col_q == COL_LAST);
  end

  always_comb begin
    hits     = '0;
    hit_code = KEY_NONE;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press_q[c][r]) begin
          hits     = hits + 5'd1;
          hit_code = key_at(4'(r * 4 + c));
        end
      end
    end
    raw = (hits == 5'd1) ? hit_code : KEY_NONE;
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned      REP_W    = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
  logic [REP_W-1:0] rep_q, rep_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_SCANS == 0);
`endif

  always_comb begin
    cand_d   = cand_q;
    match_d  = match_q;
    key_d    = key_q;
    strobe_d = 1'b0;
    commit   = 1'b0;
    if (scan_end_q) begin
      if (raw != cand_q) begin
        cand_d  = raw;
        match_d = MATCH_W'(1);
      end else if (match_q != MATCH_FULL) begin
        match_d = match_q + MATCH_W'(1);
        commit  = (match_q == MATCH_FULL - MATCH_W'(1));
      end
    end
    // Re-committing the current code is silent; only a fresh non-F code strobes.
    if (commit) begin
      key_d    = cand_q;
      strobe_d = (cand_q != KEY_NONE) && (cand_q != key_q);
    end
`ifdef KEY_REPEAT_EN
    rep_d = rep_q;
    if (scan_end_q) begin
      if (commit || key_q == KEY_NONE) begin
        rep_d = '0;
      end else if (rep_q == REP_LAST) begin
        rep_d    = '0;
        strobe_d = 1'b1;
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      col_q      <= '0;
      press_q    <= '0;
      scan_end_q <= 1'b0;
      cand_q     <= KEY_NONE;
      match_q    <= '0;
      key_q      <= KEY_NONE;
      strobe_q   <= 1'b0;
    end else begin
      div_q      <= div_d;
      col_q      <= col_d;
      press_q    <= press_d;
      scan_end_q <= scan_end_d;
      cand_q     <= cand_d;
      match_q    <= match_d;
      key_q      <= key_d;
      strobe_q   <= strobe_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  assign kp.col_out    = ~(4'b0001 << col_q);
  assign kp.key_code   = key_q;
  assign kp.key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, step table per scan, strobe scoreboard.
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int REPEAT_SCANS   = 5;
`ifdef KEY_REPEAT_EN
  localparam int HOLD_STROBES = 4;
`else
  localparam int HOLD_STROBES = 1;
`endif

  localparam logic [15:0] K_NONE = 16'h0000;
  localparam logic [15:0] K_1    = 16'h0001;
  localparam logic [15:0] K_A    = 16'h0008;
  localparam logic [15:0] K_5    = 16'h0020;
  localparam logic [15:0] K_9    = 16'h0400;
  localparam logic [15:0] K_C    = 16'h0800;
  localparam logic [15:0] K_0    = 16'h2000;
  localparam logic [15:0] K_UNU  = 16'h4000;
  localparam logic [15:0] K_D    = 16'h8000;

  typedef struct {
    string       name;
    logic [15:0] keys;
    int          scans;
    logic [3:0]  exp_code;
    int          exp_strobes;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  rows;
  int          tests = 0;
  int          fails = 0;
  int          strobe_cnt = 0;
  logic [3:0]  sb_q[$];
  logic [3:0]  sb_exp;
  vec_t        vecs[$];

  keypad_scanner_if kif();

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .REPEAT_SCANS  (REPEAT_SCANS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kif)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !kif.col_out[c]) rows[r] = 1'b0;
      end
    end
  end
  assign kif.row_in = rows;

  always @(negedge clk) begin
    if (!rst && kif.key_strobe === 1'b1) begin
      strobe_cnt++;
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL strobe_unexpected: key_code=%h, required no strobe", kif.key_code);
      end else begin
        sb_exp = sb_q.pop_front();
        if (kif.key_code !== sb_exp) begin
          fails++;
          $display("FAIL strobe_code: got %h, required %h", kif.key_code, sb_exp);
        end
      end
    end
  end

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wait_scan_start();
    logic [3:0] prev;
    bit         seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      prev = kif.col_out;
      @(negedge clk);
      if (kif.col_out == 4'b1110 && prev != 4'b1110) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL scan_timeout: col_out=%b, required a return to 1110", kif.col_out);
    end
  endtask

  task automatic add_vec(input string name, input logic [15:0] k, input int n,
                         input logic [3:0] code, input int strobes);
    vec_t v;
    v.name = name; v.keys = k; v.scans = n; v.exp_code = code; v.exp_strobes = strobes;
    vecs.push_back(v);
  endtask

  // Asynchronous reset mid-slot, then the column walk from a clean start.
  task automatic reset_check(input string name);
    logic [3:0] one_hot;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check4({name, "_col"},    kif.col_out,  4'b1110);
    check4({name, "_code"},   kif.key_code, 4'hF);
    check4({name, "_strobe"}, {3'b000, kif.key_strobe}, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      one_hot = 4'b0001 << ((k / 4) % 4);
      check4($sformatf("%s_walk%0d", name, k), kif.col_out, ~one_hot);
    end
  endtask

  initial begin
    int s0;

    add_vec("idle",         K_NONE,    3, 4'hF, 0);
    add_vec("k5_early",     K_5,       2, 4'hF, 0);
    add_vec("k5_commit",    K_5,       1, 4'h5, 1);
    add_vec("k5_rel_early", K_NONE,    2, 4'h5, 0);
    add_vec("k5_released",  K_NONE,    1, 4'hF, 0);
    add_vec("b9_on1",       K_9,       1, 4'hF, 0);
    add_vec("b9_off1",      K_NONE,    1, 4'hF, 0);
    add_vec("b9_on2",       K_9,       1, 4'hF, 0);
    add_vec("b9_off2",      K_NONE,    1, 4'hF, 0);
    add_vec("b9_on3",       K_9,       1, 4'hF, 0);
    add_vec("b9_off3",      K_NONE,    1, 4'hF, 0);
    add_vec("b9_hold2",     K_9,       2, 4'hF, 0);
    add_vec("b9_commit",    K_9,       1, 4'h9, 1);
    add_vec("b9_release",   K_NONE,    3, 4'hF, 0);
    add_vec("chord_1a",     K_1 | K_A, 4, 4'hF, 0);
    add_vec("k1_early",     K_1,       2, 4'hF, 0);
    add_vec("k1_commit",    K_1,       1, 4'h1, 1);
    add_vec("k1_release",   K_NONE,    3, 4'hF, 0);
    add_vec("unused_key",   K_UNU,     4, 4'hF, 0);
    add_vec("kc_commit",    K_C,       3, 4'hC, 1);
    add_vec("kd_early",     K_D,       2, 4'hC, 0);
    add_vec("kd_commit",    K_D,       1, 4'hD, 1);
    add_vec("kd_release",   K_NONE,    3, 4'hF, 0);
    add_vec("k0_hold20",    K_0,      20, 4'h0, HOLD_STROBES);
    add_vec("k0_release",   K_NONE,    3, 4'hF, 0);

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    reset_check("rst_init");

    foreach (vecs[i]) begin
      keys = vecs[i].keys;
      s0   = strobe_cnt;
      repeat (vecs[i].exp_strobes) sb_q.push_back(vecs[i].exp_code);
      repeat (vecs[i].scans) wait_scan_start();
      @(negedge clk);
      #1;
      check4({vecs[i].name, "_code"}, kif.key_code, vecs[i].exp_code);
      check_int({vecs[i].name, "_strobes"}, strobe_cnt - s0, vecs[i].exp_strobes);
    end

    // Reset while a committed key is held: the code drops at once and needs full debounce again.
    keys = K_5;
    s0   = strobe_cnt;
    sb_q.push_back(4'h5);
    repeat (3) wait_scan_start();
    @(negedge clk);
    #1;
    check4("pre_rst_code", kif.key_code, 4'h5);
    check_int("pre_rst_strobes", strobe_cnt - s0, 1);
    reset_check("rst_mid");
    s0 = strobe_cnt;
    wait_scan_start();
    @(negedge clk);
    #1;
    check4("post_rst_2scans_code", kif.key_code, 4'hF);
    check_int("post_rst_2scans_strobes", strobe_cnt - s0, 0);
    sb_q.push_back(4'h5);
    wait_scan_start();
    @(negedge clk);
    #1;
    check4("post_rst_commit_code", kif.key_code, 4'h5);
    check_int("post_rst_commit_strobes", strobe_cnt - s0, 1);
    check_int("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

- 4x4 matrix keypad scanner with per-scan debouncing; drives the keypad columns, samples the rows, and produces the 4-bit key code consumed by the charging-station state machine on its `key_input` port.
- Outputs hexadecimal codes 0–E for pressed keys and 4'hF for "no key", so the state machine's existing `F`/change-of-key detection works unchanged.
- Sits between the board keypad pins and the state machine, in the same `clk` domain.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column stays driven; legal range ≥2.
- `DEBOUNCE_SCANS`, default 3: number of consecutive full scans with the same decoded key needed to commit it; legal range ≥2.
- `REPEAT_SCANS`, default 40: scans between repeat strobes; used only with `KEY_REPEAT_EN`.
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `row_in`, input, 4: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_out`, output, 4: column drive, active-low, exactly one bit low at all times.
- `key_code`, output, 4: debounced key code; 4'hF means no key.
- `key_strobe`, output, 1: one-cycle pulse when a new non-F code is committed.

## Operation
- **Reset values:** `col_out`=4'b1110, `key_code`=4'hF, `key_strobe`=0. All internal state is cleared: divider count 0, column index 0, press map 0, candidate 4'hF, match count 0, repeat count 0.
- **Synchronisation:** `row_in` passes through a 2-flop synchroniser before use.
- **Column timing:** column c is driven low for `SCAN_DIV` cycles.
  - On the last cycle of the slot (divider = `SCAN_DIV`-1), the synchronised rows are inverted and stored as press bits for column c.
  - The column index then advances c→c+1, with 3→0 wrapping. `col_out` updates on that same edge.
- **Key map** (row r, column c):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, unused, D
  - The unused position decodes as 4'hF.
- **Raw decode:** at the end of each full scan (column 3 sampled), raw = the code of the single pressed key. If zero keys or two or more keys are pressed, raw = 4'hF (ghost/chord rejection).
- **Debounce:** evaluated once per scan end.
  - raw ≠ candidate: candidate←raw, match count←1.
  - raw = candidate: match count saturates at `DEBOUNCE_SCANS`. When the count goes from `DEBOUNCE_SCANS`-1 to `DEBOUNCE_SCANS`, `key_code`←candidate.
  - `key_code` therefore changes only after `DEBOUNCE_SCANS` consecutive agreeing scans. Releases (→F) are debounced the same way.
- **Strobe:** `key_strobe`=1 for exactly one cycle when `key_code` is committed to a non-F value. No strobe on commit to F. No strobe when the committed value equals the current `key_code`.
- **Direct key change** (A held, then B held with no release in between): B commits after `DEBOUNCE_SCANS` scans, with a strobe.
- **Reset mid-scan:** returns immediately to the reset values. The first commit after reset needs a full `DEBOUNCE_SCANS` scans.

## Timing
- Scan period = 4×`SCAN_DIV` cycles.
- The row sample lands on the last cycle of each column slot, so rows have `SCAN_DIV`-1 cycles to settle after the column switches.
- Decode and debounce are registered on the cycle after column 3 is sampled. `key_code` and `key_strobe` change on that edge.
- Worst-case press-to-`key_code` latency: (`DEBOUNCE_SCANS`+1) scan periods + 3 cycles. Best case: `DEBOUNCE_SCANS` scan periods + 3 cycles.
- With defaults at 50 MHz: 4 ms scan period, about 12–16 ms debounce.

## Configuration
- **`KEY_REPEAT_EN` defined:**
  - While `key_code` stays at a non-F value, a repeat counter increments every scan end.
  - Each time the counter reaches `REPEAT_SCANS`, `key_strobe` pulses for one cycle and the counter clears.
  - The counter clears on any commit.
  - `key_code` itself does not toggle.
- **`KEY_REPEAT_EN` undefined:** the repeat counter is absent, and a held key gives exactly one strobe.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3, `REPEAT_SCANS`=5 (scan = 16 cycles).

1. **Reset:** assert `rst` mid-slot.
   - Required: `col_out`=1110, `key_code`=F, `key_strobe`=0 immediately and asynchronously.
   - Required after release: `col_out` steps 1110→1101→1011→0111→1110, 4 cycles each.
2. **Clean press:** hold key "5" (row1 low while col1 driven) from a scan start.
   - Required: `key_code`=5 with a single `key_strobe` pulse at the 3rd scan end (cycle 48 + pipeline).
   - Required on release: `key_code`=F after 3 more scans, with no strobe.
3. **Bounce:** toggle "9" on alternate scans for 6 scans, then hold it.
   - Required: `key_code` stays F until 3 consecutive "9" scans, then goes to 9.
4. **Chord:** hold "1" and "A" together.
   - Required: `key_code` stays F.
   - Then release "A": `key_code`=1 after 3 scans, with a strobe.
5. **Unused key and key change:** press row3/col2.
   - Required: `key_code`=F and no strobe.
   - Then hold "C" then "D" directly (no release between): `key_code`=C then D, one strobe each.
6. **Hold with `KEY_REPEAT_EN`:** hold "0" for 20 scans.
   - Required: an initial strobe, then further strobes every 5 scans; `key_code` remains 0 throughout.
   - Without the macro: exactly one strobe.
